// File: rtl/uart_pkg.sv
// Shared UART framing constants and frame-hunter state encoding.
// Used by uart_pack_crc_framer and the CRC helper, and by the TX side.
package uart_pkg;

    localparam logic [7:0] UART_HEAD_BYTE = 8'hA5;
    localparam logic [7:0] CRC8_POLY      = 8'h07;
    localparam logic [7:0] CRC8_INIT      = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FUNC    = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } frame_state_t;

endpackage

// File: rtl/crc8_byte_calc.sv
// Combinational CRC8 update for one byte: poly 0x07, MSB-first, no reflection.
// Shared between the RX framer and the TX protocol encoder.
module crc8_byte_calc
    import uart_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_work;

    always_comb begin
        crc_work = crc_in ^ data_in;
        for (int b = 0; b < 8; b++) begin
            if (crc_work[7]) begin
                crc_work = {crc_work[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                crc_work = {crc_work[6:0], 1'b0};
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/uart_pack_crc_framer.sv
// Byte-to-packet framer: header hunt, func + payload capture, CRC8 trailer check, timeout.
// Build option: define UART_CRC_CHECK_EN to check the trailer; otherwise it is consumed unchecked.
module uart_pack_crc_framer
    import uart_pkg::*;
#(
    parameter int          _PAYLOAD_LEN = 10,
    parameter logic [7:0]  _HEAD_BYTE   = UART_HEAD_BYTE,
    parameter int          _TIMEOUT_CYC = 50000
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [7:0]                uart_data,
    input  logic                      uart_done,
    output logic [7:0]                func_reg,
    output logic [8*_PAYLOAD_LEN-1:0] pack_data,
    output logic                      pack_done,
    output logic                      crc_err,
    output logic                      timeout_err,
    output logic                      pack_ing,
    output logic [7:0]                pack_ok_cnt
);

    localparam int          IDX_W   = (_PAYLOAD_LEN > 1) ? $clog2(_PAYLOAD_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(_PAYLOAD_LEN - 1);
    localparam logic [15:0] TO_LAST = 16'(_TIMEOUT_CYC - 1);

    frame_state_t              state;
    logic [IDX_W-1:0]          idx;
    logic [15:0]               to_cnt;
    logic [7:0]                shadow_func;
    logic [8*_PAYLOAD_LEN-1:0] shadow_data;
    logic                      crc_ok;

`ifdef UART_CRC_CHECK_EN
    logic [7:0] crc_acc;
    logic [7:0] crc_seed;
    logic [7:0] crc_next;

    // The func byte restarts the accumulator so a previous frame never leaks in.
    assign crc_seed = (state == FUNC) ? CRC8_INIT : crc_acc;
    assign crc_ok   = (uart_data == crc_acc);

    crc8_byte_calc u_crc8 (
        .crc_in  (crc_seed),
        .data_in (uart_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            crc_acc <= CRC8_INIT;
            crc_err <= 1'b0;
        end else begin
            crc_err <= uart_done && (state == CHECK) && !crc_ok;
            if (uart_done && (state == FUNC || state == PAYLOAD)) begin
                crc_acc <= crc_next;
            end
        end
    end
`else
    assign crc_ok  = 1'b1;
    assign crc_err = 1'b0;
`endif

    assign pack_ing = (state != IDLE);

    // A received byte always beats a timeout expiring in the same cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            to_cnt      <= '0;
            shadow_func <= '0;
            shadow_data <= '0;
            func_reg    <= '0;
            pack_data   <= '0;
            pack_done   <= 1'b0;
            timeout_err <= 1'b0;
            pack_ok_cnt <= '0;
        end else begin
            pack_done   <= 1'b0;
            timeout_err <= 1'b0;
            if (uart_done) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (uart_data == _HEAD_BYTE) begin
                            state <= FUNC;
                        end
                    end
                    FUNC: begin
                        shadow_func <= uart_data;
                        idx         <= '0;
                        state       <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        shadow_data[8*idx +: 8] <= uart_data;
                        if (idx == IDX_LAST) begin
                            state <= CHECK;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    CHECK: begin
                        state <= IDLE;
                        if (crc_ok) begin
                            func_reg    <= shadow_func;
                            pack_data   <= shadow_data;
                            pack_done   <= 1'b1;
                            pack_ok_cnt <= pack_ok_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TO_LAST) begin
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                    to_cnt      <= '0;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_pack_crc_framer.sv
// Randomized self-checking bench for uart_pack_crc_framer against a queue-based frame model.
// Expectations follow UART_CRC_CHECK_EN the same way the design build does.
module tb_uart_pack_crc_framer;

    localparam int PLEN = 10;
    localparam int TOUT = 50000;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic [7:0]      uart_data = '0;
    logic            uart_done = 1'b0;
    logic [7:0]      func_reg;
    logic [8*PLEN-1:0] pack_data;
    logic            pack_done;
    logic            crc_err;
    logic            timeout_err;
    logic            pack_ing;
    logic [7:0]      pack_ok_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is the list of bytes after the header.
    bit              in_frame = 0;
    logic [7:0]      frame_q[$];
    logic [7:0]      exp_func = '0;
    logic [8*PLEN-1:0] exp_data = '0;
    logic [7:0]      exp_cnt = '0;

    uart_pack_crc_framer #(
        ._PAYLOAD_LEN (PLEN),
        ._HEAD_BYTE   (8'hA5),
        ._TIMEOUT_CYC (TOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .uart_data   (uart_data),
        .uart_done   (uart_done),
        .func_reg    (func_reg),
        .pack_data   (pack_data),
        .pack_done   (pack_done),
        .crc_err     (crc_err),
        .timeout_err (timeout_err),
        .pack_ing    (pack_ing),
        .pack_ok_cnt (pack_ok_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // CRC as polynomial long division over the message bit stream.
    function automatic logic [7:0] refCrc(input logic [7:0] bytes[$]);
        logic [7:0] c = 8'h00;
        logic fb;
        foreach (bytes[i]) begin
            for (int bit_n = 7; bit_n >= 0; bit_n--) begin
                fb = c[7] ^ bytes[i][bit_n];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic modelByte(input logic [7:0] b, output bit done, output bit cerr);
        logic [7:0] body[$];
        bit ok;
        done = 0;
        cerr = 0;
        if (!in_frame) begin
            if (b == 8'hA5) begin
                in_frame = 1;
                frame_q.delete();
            end
        end else begin
            frame_q.push_back(b);
            if (frame_q.size() == PLEN + 2) begin
                for (int i = 0; i < PLEN + 1; i++) body.push_back(frame_q[i]);
`ifdef UART_CRC_CHECK_EN
                ok = (refCrc(body) == b);
`else
                ok = 1;
`endif
                if (ok) begin
                    exp_func = frame_q[0];
                    for (int k = 0; k < PLEN; k++) exp_data[8*k +: 8] = frame_q[k+1];
                    exp_cnt++;
                    done = 1;
                end else begin
                    cerr = 1;
                end
                in_frame = 0;
            end
        end
    endtask

    task automatic modelReset();
        in_frame = 0;
        frame_q.delete();
        exp_func = '0;
        exp_data = '0;
        exp_cnt  = '0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".func_reg"}, 80'(func_reg), 80'(exp_func));
        checkOutput({tag, ".pack_data"}, pack_data, exp_data);
        checkOutput({tag, ".pack_ok_cnt"}, 80'(pack_ok_cnt), 80'(exp_cnt));
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bit done;
        bit cerr;
        repeat ($urandom_range(0, 2)) @(posedge sys_clk);
        @(negedge sys_clk);
        uart_data = b;
        uart_done = 1'b1;
        @(posedge sys_clk);
        #1;
        uart_done = 1'b0;
        modelByte(b, done, cerr);
        checkOutput("pack_done", 80'(pack_done), 80'(done));
        checkOutput("crc_err", 80'(crc_err), 80'(cerr));
        checkOutput("timeout_err", 80'(timeout_err), 80'(0));
        checkOutput("pack_ing", 80'(pack_ing), 80'(in_frame));
        if (done || cerr) begin
            checkAll("frame_end");
            @(posedge sys_clk);
            #1;
            checkOutput("pulse_width", 80'({pack_done, crc_err}), 80'(0));
        end
    endtask

    task automatic sendFrame(input logic [7:0] func, input logic [79:0] payload, input bit corrupt);
        logic [7:0] body[$];
        logic [7:0] trailer;
        body.push_back(func);
        for (int k = 0; k < PLEN; k++) body.push_back(payload[8*k +: 8]);
        trailer = refCrc(body) ^ (corrupt ? 8'h01 : 8'h00);
        applyStimulus(8'hA5);
        foreach (body[i]) applyStimulus(body[i]);
        applyStimulus(trailer);
    endtask

    task automatic doReset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        checkOutput("reset.pack_ing", 80'(pack_ing), 80'(0));
        checkOutput("reset.strobes", 80'({pack_done, crc_err, timeout_err}), 80'(0));
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [79:0] pl;

        doReset();

        // Frame 1 and the nine-zeros-then-01 frame with trailer 07.
        sendFrame(8'h00, 80'h0, 0);
        pl = 80'h01 << 72;
        sendFrame(8'h00, pl, 0);
        checkOutput("frame2.last_byte", 80'(pack_data[79:72]), 80'h01);

        // Bad trailer: crc_err with the check built in, pack_done without it.
        sendFrame(8'h00, 80'h0, 1);

        // Timeout after five payload bytes.
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        for (int k = 0; k < 5; k++) applyStimulus(8'($urandom));
        n = 0;
        while (n <= TOUT + 100) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (timeout_err) break;
        end
        in_frame = 0;
        frame_q.delete();
        checkOutput("timeout_cycles", 80'(n), 80'(TOUT));
        checkOutput("timeout.pack_ing", 80'(pack_ing), 80'(0));
        checkAll("timeout");
        @(posedge sys_clk);
        #1;
        checkOutput("timeout.pulse", 80'(timeout_err), 80'(0));
        sendFrame(8'h00, 80'h0, 0);

        // Garbage before the header, header value inside the payload.
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        pl = {$urandom, $urandom, $urandom};
        pl[23:16] = 8'hA5;
        sendFrame(8'h5A, pl, 0);
        checkOutput("hdr_as_data", 80'(pack_data[23:16]), 80'hA5);

        // Random frames, roughly a quarter with a corrupted trailer.
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(8'($urandom));
            pl = {$urandom, $urandom, $urandom};
            sendFrame(8'($urandom), pl, $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a payload.
        applyStimulus(8'hA5);
        applyStimulus(8'h42);
        for (int k = 0; k < 3; k++) applyStimulus(8'($urandom));
        doReset();
        sendFrame(8'h00, 80'h0, 0);
        checkOutput("post_reset.cnt", 80'(pack_ok_cnt), 80'h01);

        // Counter wrap after 256 good frames from reset.
        doReset();
        for (int f = 0; f < 256; f++) begin
            pl = {$urandom, $urandom, $urandom};
            sendFrame(8'($urandom), pl, 0);
        end
        checkOutput("cnt_wrap", 80'(pack_ok_cnt), 80'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
